// File: rtl/ex_stage.sv
// MIPS execute stage: integer ALU, single-cycle multiplier, 32-iteration restoring
// divider and the HI/LO registers. Raises stall_req while a divide is in flight.
module ex_stage #(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int REG_DATA_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      flush,
    input  logic                      valid_in,
    input  logic [4:0]                alu_op,
    input  logic [REG_DATA_WIDTH-1:0] op_a,
    input  logic [REG_DATA_WIDTH-1:0] op_b,
    input  logic [REG_ADDR_WIDTH-1:0] w_reg_addr_in,
    input  logic                      w_reg_en_in,
    output logic [REG_ADDR_WIDTH-1:0] w_reg_addr_out,
    output logic [REG_DATA_WIDTH-1:0] w_reg_data_out,
    output logic                      w_reg_en_out,
    output logic                      stall_req
);

    localparam int W  = REG_DATA_WIDTH;
    localparam int CW = $clog2(W);

    typedef enum logic [4:0] {
        OP_ADD  = 5'd0,  OP_SUB  = 5'd1,  OP_AND  = 5'd2,  OP_OR    = 5'd3,
        OP_XOR  = 5'd4,  OP_NOR  = 5'd5,  OP_SLT  = 5'd6,  OP_SLTU  = 5'd7,
        OP_SLL  = 5'd8,  OP_SRL  = 5'd9,  OP_SRA  = 5'd10, OP_MFHI  = 5'd11,
        OP_MFLO = 5'd12, OP_MTHI = 5'd13, OP_MTLO = 5'd14, OP_MULT  = 5'd15,
        OP_MULTU = 5'd16, OP_DIV = 5'd17, OP_DIVU = 5'd18
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_e;

    state_e         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [W-1:0]   hi_q, hi_d;
    logic [W-1:0]   lo_q, lo_d;
    logic [W-1:0]   quo_q, quo_d;
    logic [W-1:0]   rem_q, rem_d;
    logic [W-1:0]   dvs_q, dvs_d;
    logic           qneg_q, qneg_d;
    logic           rneg_q, rneg_d;

    logic           issue;
    logic           is_div;
    logic           no_wb;
    logic [CW-1:0]  shamt;
    logic [W-1:0]   result;
    logic [2*W-1:0] prod_s;
    logic [2*W-1:0] prod_u;
    logic           a_neg;
    logic           b_neg;
    logic [W-1:0]   a_abs;
    logic [W-1:0]   b_abs;
    logic [W:0]     partial;
    logic [W:0]     diff;

    assign issue  = valid_in & ~flush;
    assign is_div = (alu_op == OP_DIV) || (alu_op == OP_DIVU);
    assign no_wb  = (alu_op >= OP_MTHI) && (alu_op <= OP_DIVU);
    assign shamt  = op_b[CW-1:0];

    assign stall_req = rst_n & issue & is_div & (state_q != S_DONE);

    // Sign-extending to 2W bits makes the low 2W bits of the product the signed result.
    assign prod_s = {{W{op_a[W-1]}}, op_a} * {{W{op_b[W-1]}}, op_b};
    assign prod_u = {{W{1'b0}}, op_a} * {{W{1'b0}}, op_b};

    assign a_neg = (alu_op == OP_DIV) & op_a[W-1];
    assign b_neg = (alu_op == OP_DIV) & op_b[W-1];
    assign a_abs = a_neg ? -op_a : op_a;
    assign b_abs = b_neg ? -op_b : op_b;

    // Remainder stays below the divisor, so the shifted partial fits in W+1 bits.
    assign partial = {rem_q, quo_q[W-1]};
    assign diff    = partial - {1'b0, dvs_q};

    always_comb begin
        result = '0;
        case (alu_op)
            OP_ADD:  result = op_a + op_b;
            OP_SUB:  result = op_a - op_b;
            OP_AND:  result = op_a & op_b;
            OP_OR:   result = op_a | op_b;
            OP_XOR:  result = op_a ^ op_b;
            OP_NOR:  result = ~(op_a | op_b);
            OP_SLT:  result = {{(W-1){1'b0}}, $signed(op_a) < $signed(op_b)};
            OP_SLTU: result = {{(W-1){1'b0}}, op_a < op_b};
            OP_SLL:  result = op_a << shamt;
            OP_SRL:  result = op_a >> shamt;
            OP_SRA:  result = $signed(op_a) >>> shamt;
            OP_MFHI: result = hi_q;
            OP_MFLO: result = lo_q;
            default: result = '0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dvs_d   = dvs_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        if (flush) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (valid_in) begin
                        case (alu_op)
                            OP_MTHI:  hi_d = op_a;
                            OP_MTLO:  lo_d = op_a;
                            OP_MULT:  {hi_d, lo_d} = prod_s;
                            OP_MULTU: {hi_d, lo_d} = prod_u;
                            default:  ;
                        endcase
                        if (is_div) begin
                            if (op_b == '0) begin
                                state_d = S_DONE;
                                quo_d   = '1;
                                rem_d   = op_a;
                                qneg_d  = 1'b0;
                                rneg_d  = 1'b0;
                            end else begin
                                state_d = S_BUSY;
                                quo_d   = a_abs;
                                rem_d   = '0;
                                dvs_d   = b_abs;
                                qneg_d  = a_neg ^ b_neg;
                                rneg_d  = a_neg;
                                cnt_d   = '0;
                            end
                        end
                    end
                end
                S_BUSY: begin
                    if (!diff[W]) begin
                        rem_d = diff[W-1:0];
                        quo_d = {quo_q[W-2:0], 1'b1};
                    end else begin
                        rem_d = partial[W-1:0];
                        quo_d = {quo_q[W-2:0], 1'b0};
                    end
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CW'(W - 1)) begin
                        state_d = S_DONE;
                    end
                end
                S_DONE: begin
                    lo_d    = qneg_q ? -quo_q : quo_q;
                    hi_d    = rneg_q ? -rem_q : rem_q;
                    state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            dvs_q   <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dvs_q   <= dvs_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
        end
    end

    assign w_reg_addr_out = w_reg_addr_in;
    assign w_reg_data_out = rst_n ? result : '0;
    assign w_reg_en_out   = rst_n & issue & w_reg_en_in & ~stall_req & ~no_wb;

endmodule

// File: tb/tb_ex_stage.sv
// Scoreboard bench for ex_stage: issued instructions queue their expected write-back,
// a negedge monitor checks each one as it leaves the stage.
module tb_ex_stage;

    localparam logic [4:0] ADD = 5'd0,  SUB = 5'd1,  AND_ = 5'd2, OR_ = 5'd3;
    localparam logic [4:0] XOR_ = 5'd4, NOR_ = 5'd5, SLT = 5'd6,  SLTU = 5'd7;
    localparam logic [4:0] SLL = 5'd8,  SRL = 5'd9,  SRA = 5'd10, MFHI = 5'd11;
    localparam logic [4:0] MFLO = 5'd12, MTHI = 5'd13, MTLO = 5'd14, MULT = 5'd15;
    localparam logic [4:0] MULTU = 5'd16, DIV = 5'd17, DIVU = 5'd18, RSVD = 5'd20;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        valid_in;
    logic [4:0]  alu_op;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [4:0]  w_reg_addr_in;
    logic        w_reg_en_in;
    logic [4:0]  w_reg_addr_out;
    logic [31:0] w_reg_data_out;
    logic        w_reg_en_out;
    logic        stall_req;

    typedef struct {
        string       name;
        logic [31:0] data;
        bit          chk_data;
        logic        en;
        logic [4:0]  addr;
        int          stall;
    } exp_t;

    exp_t       exp_q[$];
    int         passed = 0;
    int         total = 0;
    int         stall_cnt = 0;
    logic [4:0] addr_ctr = 5'd0;

    ex_stage #(.REG_ADDR_WIDTH(5), .REG_DATA_WIDTH(32)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .flush         (flush),
        .valid_in      (valid_in),
        .alu_op        (alu_op),
        .op_a          (op_a),
        .op_b          (op_b),
        .w_reg_addr_in (w_reg_addr_in),
        .w_reg_en_in   (w_reg_en_in),
        .w_reg_addr_out(w_reg_addr_out),
        .w_reg_data_out(w_reg_data_out),
        .w_reg_en_out  (w_reg_en_out),
        .stall_req     (stall_req)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: actual=%h required=%h", name, act, exp);
    endtask

    // Monitor: an instruction leaves the stage on a cycle with valid_in & ~stall_req.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && valid_in && !flush) begin
            if (stall_req) begin
                stall_cnt++;
                check("en_during_stall", {31'd0, w_reg_en_out}, 32'd0);
            end else begin
                if (exp_q.size() == 0) begin
                    total++;
                    $display("FAIL unexpected_retire: actual=op %0d required=none", alu_op);
                end else begin
                    e = exp_q.pop_front();
                    if (e.chk_data) check({e.name, "_data"}, w_reg_data_out, e.data);
                    check({e.name, "_en"}, {31'd0, w_reg_en_out}, {31'd0, e.en});
                    check({e.name, "_addr"}, {27'd0, w_reg_addr_out}, {27'd0, e.addr});
                    check({e.name, "_stall"}, 32'(stall_cnt), 32'(e.stall));
                end
                stall_cnt = 0;
            end
        end else begin
            stall_cnt = 0;
        end
    end

    task automatic issue(input string name, input logic [4:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic wen, input logic [31:0] exp_data,
                         input bit chk_d, input logic exp_en, input int exp_stall);
        exp_t e;
        int   n;
        logic s;
        addr_ctr      = addr_ctr + 5'd1;
        alu_op        = op;
        op_a          = a;
        op_b          = b;
        w_reg_addr_in = addr_ctr;
        w_reg_en_in   = wen;
        valid_in      = 1'b1;
        e.name = name; e.data = exp_data; e.chk_data = chk_d;
        e.en = exp_en; e.addr = addr_ctr; e.stall = exp_stall;
        exp_q.push_back(e);
        n = 0;
        do begin
            @(negedge clk);
            s = stall_req;
            @(posedge clk);
            n++;
        end while (s && n < 100);
        if (s) begin
            total++;
            $display("FAIL %s_timeout: actual=stalled %0d cycles required=release", name, n);
        end
        #1;
    endtask

    task automatic alu(input string name, input logic [4:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp_data);
        issue(name, op, a, b, 1'b1, exp_data, 1'b1, 1'b1, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; flush = 1'b0; valid_in = 1'b1; w_reg_en_in = 1'b1;
        w_reg_addr_in = 5'd0; alu_op = DIV; op_a = 32'd9; op_b = 32'd3;
        #1;
        check("rst_stall", {31'd0, stall_req}, 32'd0);
        alu_op = ADD; op_a = 32'd1; op_b = 32'd1;
        #1;
        check("rst_data", w_reg_data_out, 32'd0);
        check("rst_en", {31'd0, w_reg_en_out}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        issue("rst_hi", MFHI, 32'd0, 32'd0, 1'b1, 32'd0, 1'b1, 1'b1, 0);
        issue("rst_lo", MFLO, 32'd0, 32'd0, 1'b1, 32'd0, 1'b1, 1'b1, 0);

        alu("add_wrap", ADD,  32'hFFFF_FFFF, 32'd2,         32'h0000_0001);
        alu("sub",      SUB,  32'd5,         32'd7,         32'hFFFF_FFFE);
        alu("and",      AND_, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000);
        alu("or",       OR_,  32'h0000_F0F0, 32'h0000_0F0F, 32'h0000_FFFF);
        alu("xor",      XOR_, 32'h0000_FF00, 32'h0000_0FF0, 32'h0000_F0F0);
        alu("nor",      NOR_, 32'd0,         32'd0,         32'hFFFF_FFFF);
        alu("slt",      SLT,  32'hFFFF_FFFF, 32'd1,         32'd1);
        alu("sltu",     SLTU, 32'hFFFF_FFFF, 32'd1,         32'd0);
        alu("sll",      SLL,  32'd1,         32'd31,        32'h8000_0000);
        alu("srl",      SRL,  32'h8000_0000, 32'h24,        32'h0800_0000);
        alu("sra",      SRA,  32'h8000_0000, 32'd4,         32'hF800_0000);
        alu("rsvd",     RSVD, 32'd1,         32'd1,         32'd0);
        issue("add_nowen", ADD, 32'd3, 32'd4, 1'b0, 32'd7, 1'b1, 1'b0, 0);

        issue("mult",   MULT,  32'hFFFF_FFFD, 32'd5, 1'b1, 32'd0, 1'b0, 1'b0, 0);
        issue("mult_lo", MFLO, 32'd0, 32'd0, 1'b1, 32'hFFFF_FFF1, 1'b1, 1'b1, 0);
        issue("mult_hi", MFHI, 32'd0, 32'd0, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b1, 0);
        issue("multu",  MULTU, 32'hFFFF_FFFF, 32'd2, 1'b1, 32'd0, 1'b0, 1'b0, 0);
        issue("multu_hi", MFHI, 32'd0, 32'd0, 1'b1, 32'd1, 1'b1, 1'b1, 0);
        issue("multu_lo", MFLO, 32'd0, 32'd0, 1'b1, 32'hFFFF_FFFE, 1'b1, 1'b1, 0);

        issue("div_neg", DIV, 32'hFFFF_FFF9, 32'd2, 1'b1, 32'd0, 1'b0, 1'b0, 33);
        issue("div_neg_lo", MFLO, 32'd0, 32'd0, 1'b1, 32'hFFFF_FFFD, 1'b1, 1'b1, 0);
        issue("div_neg_hi", MFHI, 32'd0, 32'd0, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b1, 0);
        issue("divu", DIVU, 32'd100, 32'd7, 1'b1, 32'd0, 1'b0, 1'b0, 33);
        issue("divu_lo", MFLO, 32'd0, 32'd0, 1'b1, 32'd14, 1'b1, 1'b1, 0);
        issue("divu_hi", MFHI, 32'd0, 32'd0, 1'b1, 32'd2, 1'b1, 1'b1, 0);
        issue("div0", DIV, 32'd5, 32'd0, 1'b1, 32'd0, 1'b0, 1'b0, 1);
        issue("div0_lo", MFLO, 32'd0, 32'd0, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b1, 0);
        issue("div0_hi", MFHI, 32'd0, 32'd0, 1'b1, 32'd5, 1'b1, 1'b1, 0);
        issue("div_ovf", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'd0, 1'b0, 1'b0, 33);
        issue("div_ovf_lo", MFLO, 32'd0, 32'd0, 1'b1, 32'h8000_0000, 1'b1, 1'b1, 0);
        issue("div_ovf_hi", MFHI, 32'd0, 32'd0, 1'b1, 32'd0, 1'b1, 1'b1, 0);

        issue("mthi", MTHI, 32'h0000_1234, 32'd0, 1'b1, 32'd0, 1'b0, 1'b0, 0);
        issue("mthi_rd", MFHI, 32'd0, 32'd0, 1'b1, 32'h0000_1234, 1'b1, 1'b1, 0);
        issue("mtlo", MTLO, 32'h0000_5678, 32'd0, 1'b1, 32'd0, 1'b0, 1'b0, 0);
        issue("mtlo_rd", MFLO, 32'd0, 32'd0, 1'b1, 32'h0000_5678, 1'b1, 1'b1, 0);

        // Divide aborted by flush in its tenth BUSY cycle.
        alu_op = DIV; op_a = 32'd100; op_b = 32'd3; w_reg_en_in = 1'b1; valid_in = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        flush = 1'b1;
        #1;
        check("flush_stall", {31'd0, stall_req}, 32'd0);
        check("flush_en", {31'd0, w_reg_en_out}, 32'd0);
        @(posedge clk);
        #1;
        flush = 1'b0; valid_in = 1'b0;
        issue("flush_hi", MFHI, 32'd0, 32'd0, 1'b1, 32'h0000_1234, 1'b1, 1'b1, 0);
        issue("flush_lo", MFLO, 32'd0, 32'd0, 1'b1, 32'h0000_5678, 1'b1, 1'b1, 0);
        issue("divu_after", DIVU, 32'd9, 32'd3, 1'b1, 32'd0, 1'b0, 1'b0, 33);
        issue("divu_after_lo", MFLO, 32'd0, 32'd0, 1'b1, 32'd3, 1'b1, 1'b1, 0);
        issue("divu_after_hi", MFHI, 32'd0, 32'd0, 1'b1, 32'd0, 1'b1, 1'b1, 0);

        // MTHI arriving together with flush must not reach HI.
        alu_op = MTHI; op_a = 32'h0000_DEAD; valid_in = 1'b1; flush = 1'b1;
        #1;
        check("flush_mthi_en", {31'd0, w_reg_en_out}, 32'd0);
        @(posedge clk);
        #1;
        flush = 1'b0; valid_in = 1'b0;
        issue("flush_mthi_hi", MFHI, 32'd0, 32'd0, 1'b1, 32'd0, 1'b1, 1'b1, 0);

        // Reset in the middle of a divide.
        issue("pre_mtlo", MTLO, 32'h0000_0077, 32'd0, 1'b1, 32'd0, 1'b0, 1'b0, 0);
        issue("pre_mthi", MTHI, 32'h0000_0099, 32'd0, 1'b1, 32'd0, 1'b0, 1'b0, 0);
        alu_op = DIVU; op_a = 32'd100; op_b = 32'd7; valid_in = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_stall", {31'd0, stall_req}, 32'd0);
        alu_op = ADD; op_a = 32'd2; op_b = 32'd3;
        #1;
        check("midrst_data", w_reg_data_out, 32'd0);
        check("midrst_en", {31'd0, w_reg_en_out}, 32'd0);
        @(posedge clk);
        #1;
        valid_in = 1'b0; rst_n = 1'b1;
        issue("midrst_hi", MFHI, 32'd0, 32'd0, 1'b1, 32'd0, 1'b1, 1'b1, 0);
        issue("midrst_lo", MFLO, 32'd0, 32'd0, 1'b1, 32'd0, 1'b1, 1'b1, 0);

        valid_in = 1'b0;
        repeat (3) @(posedge clk);
        check("drain", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/ex_stage.md
# ex_stage

Execute stage of the MIPS pipeline: it sits between the id_ex register and the ex_mem register, and drives the ex_mem write-back inputs (address, data, enable). It contains the integer ALU, a single-cycle 32x32 multiplier, a 32-cycle iterative restoring divider, and the architectural HI/LO registers. While a divide is in progress it raises a stall request that freezes the upstream stages.

## Interface
Parameters:
- REG_ADDR_WIDTH, 5, register-file address width
- REG_DATA_WIDTH, 32, datapath width; the divider counter and multiplier are sized from it

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- flush  in  1  kill the current instruction and abort any divide
- valid_in  in  1  the id_ex slot holds a real instruction
- alu_op  in  5  operation code (see Operation)
- op_a  in  REG_DATA_WIDTH  rs operand
- op_b  in  REG_DATA_WIDTH  rt operand or immediate
- w_reg_addr_in  in  REG_ADDR_WIDTH  destination register
- w_reg_en_in  in  1  instruction writes a GPR
- w_reg_addr_out  out  REG_ADDR_WIDTH  to ex_mem
- w_reg_data_out  out  REG_DATA_WIDTH  to ex_mem
- w_reg_en_out  out  1  to ex_mem
- stall_req  out  1  hold id_ex and earlier stages; ex_mem captures a bubble

## Operation
- alu_op codes:
  - 0 ADD, 1 SUB: both modulo 2^32, no overflow trap.
  - 2 AND, 3 OR, 4 XOR, 5 NOR.
  - 6 SLT: signed compare. 7 SLTU: unsigned compare. Result is 1 or 0.
  - 8 SLL, 9 SRL, 10 SRA: shift op_a by op_b[4:0].
  - 11 MFHI, 12 MFLO: return the current HI or LO value.
  - 13 MTHI, 14 MTLO: copy op_a into HI or LO.
  - 15 MULT, 16 MULTU: {HI,LO} <= 64-bit product, signed or unsigned.
  - 17 DIV, 18 DIVU: LO <= quotient, HI <= remainder.
  - 19-31: result 0, no HI/LO effect.
- w_reg_addr_out = w_reg_addr_in. w_reg_data_out = ALU result, combinational.
- w_reg_en_out = valid_in & w_reg_en_in & ~flush & ~stall_req. It is forced to 0 for codes 13-18.
- HI/LO writes for codes 13-16 occur at the clock edge when valid_in & ~flush. Those codes never stall.
- Divider FSM, states IDLE, BUSY, DONE:
  - IDLE -> BUSY: on valid_in & ~flush & DIV/DIVU & op_b != 0. Latch |op_a|, |op_b| (the unsigned operands for DIVU), the quotient sign (sign(a) XOR sign(b)) and the remainder sign (sign(a)). Clear the counter.
  - IDLE -> DONE: on a divide with op_b == 0. Result is Q = all ones, R = op_a.
  - BUSY: one restoring shift/subtract per cycle. After 32 iterations (counter = 31) -> DONE.
  - DONE: apply sign correction. The quotient is negated if the signs differ; the remainder takes the sign of the dividend. Write LO/HI at the clock edge, then -> IDLE.
  - 0x80000000 / -1 with DIV gives LO = 0x80000000, HI = 0. This falls out of the modulo arithmetic.
- stall_req = valid_in & ~flush & (alu_op is DIV/DIVU) & (state != DONE).
- flush in any state: FSM -> IDLE, HI/LO unchanged, stall_req = 0 in the same cycle.
- Upstream holds alu_op and the operands stable while stall_req = 1. The divider uses only its latched copies.

## Timing
- ALU, MFHI/MFLO and shifts: zero-cycle combinational; the result is registered by ex_mem at the next edge.
- HI/LO write: MTHI/MTLO/MULT/MULTU at the issue edge. An MFHI/MFLO in the immediately following cycle sees the new value.
- DIV/DIVU with nonzero divisor:
  - The instruction occupies the stage for 34 cycles: issue (IDLE), 32 BUSY, 1 DONE.
  - stall_req is high for the first 33 of them.
  - HI/LO are updated at the end of the DONE cycle.
  - The instruction leaves the stage at the same edge.
- Divide by zero: 2 cycles (IDLE, then DONE), with stall_req high for 1 cycle.
- Reset (rst_n = 0 at an edge) forces:
  - HI = 0, LO = 0, FSM = IDLE, counter = 0.
  - While rst_n = 0: stall_req = 0, w_reg_en_out = 0, w_reg_data_out = 0.
  - Reset during BUSY aborts the divide with no HI/LO write.
- An instruction arriving in the same cycle as flush produces no GPR or HI/LO write.

## Test plan
- ADD 0xFFFFFFFF + 2 -> data 0x00000001, en 1. SLT 0xFFFFFFFF, 1 -> 1. SLTU same operands -> 0. SRA 0x80000000 by 4 -> 0xF8000000.
- MULT -3 x 5 -> HI 0xFFFFFFFF, LO 0xFFFFFFF1. MFLO next cycle returns 0xFFFFFFF1. MULTU 0xFFFFFFFF x 2 -> HI 1, LO 0xFFFFFFFE.
- DIV -7 / 2 -> stall_req high exactly 33 cycles, then LO 0xFFFFFFFD, HI 0xFFFFFFFF. w_reg_en_out 0 throughout. DIVU 100 / 7 -> LO 14, HI 2.
- DIV 5 / 0 -> stall 1 cycle; LO 0xFFFFFFFF, HI 5. DIV 0x80000000 / 0xFFFFFFFF -> LO 0x80000000, HI 0.
- Start a DIV, assert flush on BUSY cycle 10 -> stall_req drops the same cycle, FSM returns to IDLE, HI/LO keep their prior values. A following DIVU 9/3 completes normally: LO 3, HI 0.
- MTHI 0x1234 then MFHI back-to-back -> data 0x1234. Assert rst_n = 0 mid-divide -> HI/LO = 0, stall_req = 0, w_reg_en_out = 0.
